bp_me_accel_wr_sink: RTL and testbench
======================================

BP_ME_ACCEL_WR_SINK -- requirements
Module: bp_me_accel_wr_sink

Interface
REQ-001 Params, one per line: name, default, meaning.
- bp_params_p, e_bp_default_cfg, proc config; supplies paddr_width_p, bedrock_fill_width_p (64) and the BedRock mem header widths.
- els_p, 16, number of 128b buffer entries; power of 2.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk_i, in, 1, sole clock.
- reset_n_i, in, 1, reset; asynchronous, active-low.
- mem_fwd_header_i, in, mem_fwd_header_width_lp, bp_bedrock_mem_fwd_header_s; held constant on every beat of a message.
- mem_fwd_data_i, in, 64, fwd data beat.
- mem_fwd_v_i, in, 1, fwd beat valid.
- mem_fwd_ready_and_o, out, 1, fwd beat accepted when high together with v.
- mem_rev_header_o, out, mem_rev_header_width_lp, response header.
- mem_rev_data_o, out, 64, response data beat.
- mem_rev_v_o, out, 1, rev beat valid.
- mem_rev_ready_and_i, in, 1, rev beat accepted when high together with v.
- wr_count_o, out, 16, count of completed write messages; wraps at 2^16.
- error_o, out, 1, sticky error flag.

Function
REQ-003 Block is the memory-side responder for uncached accelerator writes; it stores write data in an els_p x 128b buffer and returns it on uncached reads.
REQ-004 Entry index = addr[4+:log2(els_p)]; half select = addr[3]; addr bits above the index are ignored.
REQ-005 Supported: msg_type e_bedrock_mem_uc_wr / e_bedrock_mem_uc_rd; size e_bedrock_msg_size_8 (1 beat) / e_bedrock_msg_size_16 (2 beats).
REQ-006 FSM states: e_ready, e_wr_data, e_resp, e_rd_data.
REQ-007 e_ready: mem_fwd_ready_and_o=1; a handshake latches the header and consumes beat 0.
- uc_wr size_8: beat writes half addr[3] of the entry; go to e_resp.
- uc_wr size_16: beat writes low half; go to e_wr_data.
- uc_rd: data beat ignored; go to e_rd_data.
REQ-008 e_wr_data: ready_and=1; a handshake writes the high half; go to e_resp.
REQ-009 e_resp: one header-only rev beat; data=0; header fields msg_type, addr, size, payload, subop copied from the latched fwd header. On handshake: increment wr_count_o; go to e_ready.
REQ-010 e_rd_data: rev header as in REQ-009.
- size_8: one beat carrying the addressed half.
- size_16: beat 0 = low half, beat 1 = high half.
- Go to e_ready after the last handshake.
REQ-011 mem_fwd_ready_and_o=0 in e_resp and e_rd_data.
REQ-012 Once rev_v is asserted, rev header and data stay stable until the handshake.
REQ-013 A read in the cycle after a write completes to the same entry returns the new data; no bypass hazard is permitted.
REQ-014 Error cases set error_o, which stays set until reset:
- Unsupported msg_type or size: all fwd beats for the declared size are consumed and discarded; 2 beats assumed when size>16B. A header-only response is still sent; no buffer write; no count.
- size_16 with addr[3]=1: same handling as above.
REQ-015 wr_count_o increments only on the e_resp handshake of a legal write, then wraps 0xFFFF -> 0x0000.
REQ-016 Throughput: a 2-beat write takes 3 cycles minimum from first fwd handshake to rev handshake, with no bubbles under continuous ready/valid.
REQ-017 No combinational path from mem_rev_ready_and_i to mem_fwd_ready_and_o, or from mem_fwd_v_i to mem_rev_v_o.

Reset
REQ-018 Asserting reset_n_i low asynchronously forces:
- FSM to e_ready.
- wr_count_o=0, error_o=0, mem_rev_v_o=0, mem_fwd_ready_and_o=0.
REQ-019 Buffer contents are not reset; a read before any write returns unspecified data.
REQ-020 Reset mid-message abandons the message; the first fwd beat after release is treated as a new header.
REQ-021 mem_fwd_ready_and_o rises in the first clk_i edge after reset_n_i deasserts.

Verification
REQ-022 Directed scenarios a bench must cover:
- Write, size_16, addr 0x20, data 0x1111.., 0x2222.. -> one rev header with uc_wr, addr 0x20; wr_count_o=1; a following size_16 read at 0x20 returns 0x1111.. then 0x2222...
- Write, size_8, addr 0x38, data 0xAB.. -> entry 3 high half becomes 0xAB.., low half unchanged; a size_8 read at 0x30 returns the old low half.
- Two back-to-back size_16 writes with ready always high -> exactly 6 cycles total, wr_count_o=2.
- mem_rev_ready_and_i held low 5 cycles during a read -> rev data/header stable throughout; mem_fwd_ready_and_o=0 throughout.
- Write, size_16, addr 0x08 -> error_o=1, both beats consumed, response sent, wr_count_o unchanged, entry 0 unchanged.
- reset_n_i pulsed low after beat 0 of a size_16 write -> count=0, FSM e_ready; the next beat is taken as a new header.

Source files
------------

// File: rtl/bp_me_accel_wr_sink.sv
// Memory-side responder for uncached accelerator writes/reads into an els_p x 128b buffer.
// 1-cycle turnaround per beat; fwd is stalled while the response drains, rev holds until accepted.
package bp_me_accel_wr_sink_pkg;
    typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

    localparam int paddr_width_p        = 40;
    localparam int bedrock_fill_width_p = 64;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [7:0]               payload;
        logic [2:0]               size;
        logic [paddr_width_p-1:0] addr;
        logic [3:0]               subop;
        logic [3:0]               msg_type;
    } bp_bedrock_mem_header_s;

    typedef bp_bedrock_mem_header_s bp_bedrock_mem_fwd_header_s;
    typedef bp_bedrock_mem_header_s bp_bedrock_mem_rev_header_s;

    localparam int mem_fwd_header_width_lp = $bits(bp_bedrock_mem_fwd_header_s);
    localparam int mem_rev_header_width_lp = $bits(bp_bedrock_mem_rev_header_s);
endpackage

module bp_me_accel_wr_sink
    import bp_me_accel_wr_sink_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int         els_p       = 16,
    localparam int        fill_width_lp = (bp_params_p == e_bp_default_cfg) ? bedrock_fill_width_p
                                                                            : bedrock_fill_width_p
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  bp_bedrock_mem_fwd_header_s mem_fwd_header_i,
    input  logic [fill_width_lp-1:0]   mem_fwd_data_i,
    input  logic                       mem_fwd_v_i,
    output logic                       mem_fwd_ready_and_o,
    output bp_bedrock_mem_rev_header_s mem_rev_header_o,
    output logic [fill_width_lp-1:0]   mem_rev_data_o,
    output logic                       mem_rev_v_o,
    input  logic                       mem_rev_ready_and_i,
    output logic [15:0]                wr_count_o,
    output logic                       error_o
);
    localparam int lg_els_lp = $clog2(els_p);

    typedef enum logic [1:0] {e_ready, e_wr_data, e_resp, e_rd_data} state_e;

    state_e                     state_q, state_d;
    bp_bedrock_mem_fwd_header_s hdr_q, hdr_d;
    logic                       drop_q, drop_d;     // current message is illegal: swallow data, no write, no count
    logic                       beat_q, beat_d;
    logic                       error_q, error_d;
    logic [15:0]                wr_count_q, wr_count_d;
    logic                       rdy_en_q;

    logic [2*fill_width_lp-1:0] buf_q [els_p];
    logic                       wr_en, wr_hi;
    logic [lg_els_lp-1:0]       wr_idx;

    logic fwd_rdy, fwd_hs, rev_hs;
    logic is_wr_in, is_rd_in, sz8_in, sz16_in, legal_in, two_in;
    logic rd_hi;
    logic [2*fill_width_lp-1:0] rd_word;

    assign is_wr_in = mem_fwd_header_i.msg_type == e_bedrock_mem_uc_wr;
    assign is_rd_in = mem_fwd_header_i.msg_type == e_bedrock_mem_uc_rd;
    assign sz8_in   = mem_fwd_header_i.size == e_bedrock_msg_size_8;
    assign sz16_in  = mem_fwd_header_i.size == e_bedrock_msg_size_16;
    assign two_in   = mem_fwd_header_i.size >= e_bedrock_msg_size_16;
    assign legal_in = (is_wr_in | is_rd_in) & (sz8_in | (sz16_in & ~mem_fwd_header_i.addr[3]));

    // Handshake qualifiers come from registered state only, so no ready/valid loops form.
    assign fwd_rdy     = rdy_en_q & ((state_q == e_ready) | (state_q == e_wr_data));
    assign mem_rev_v_o = (state_q == e_resp) | (state_q == e_rd_data);
    assign fwd_hs      = mem_fwd_v_i & fwd_rdy;
    assign rev_hs      = mem_rev_v_o & mem_rev_ready_and_i;

    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        drop_d     = drop_q;
        beat_d     = beat_q;
        error_d    = error_q;
        wr_count_d = wr_count_q;
        wr_en      = 1'b0;
        wr_hi      = 1'b0;
        wr_idx     = hdr_q.addr[4 +: lg_els_lp];
        case (state_q)
            e_ready: if (fwd_hs) begin
                hdr_d  = mem_fwd_header_i;
                drop_d = ~legal_in;
                beat_d = 1'b0;
                wr_idx = mem_fwd_header_i.addr[4 +: lg_els_lp];
                if (!legal_in) begin
                    error_d = 1'b1;
                    state_d = two_in ? e_wr_data : e_resp;
                end else if (is_rd_in) begin
                    state_d = e_rd_data;
                end else begin
                    wr_en   = 1'b1;
                    wr_hi   = sz8_in & mem_fwd_header_i.addr[3];
                    state_d = sz16_in ? e_wr_data : e_resp;
                end
            end
            e_wr_data: if (fwd_hs) begin
                wr_en   = ~drop_q;
                wr_hi   = 1'b1;
                state_d = e_resp;
            end
            e_resp: if (rev_hs) begin
                if (!drop_q) wr_count_d = wr_count_q + 16'd1;
                state_d = e_ready;
            end
            e_rd_data: if (rev_hs) begin
                if ((hdr_q.size == e_bedrock_msg_size_16) && !beat_q) beat_d = 1'b1;
                else state_d = e_ready;
            end
            default: state_d = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_ready;
            hdr_q      <= '0;
            drop_q     <= 1'b0;
            beat_q     <= 1'b0;
            error_q    <= 1'b0;
            wr_count_q <= '0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            drop_q     <= drop_d;
            beat_q     <= beat_d;
            error_q    <= error_d;
            wr_count_q <= wr_count_d;
            rdy_en_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            if (wr_hi) buf_q[wr_idx][2*fill_width_lp-1:fill_width_lp] <= mem_fwd_data_i;
            else       buf_q[wr_idx][fill_width_lp-1:0]               <= mem_fwd_data_i;
        end
    end

    assign rd_hi   = (hdr_q.size == e_bedrock_msg_size_16) ? beat_q : hdr_q.addr[3];
    assign rd_word = buf_q[hdr_q.addr[4 +: lg_els_lp]];

    assign mem_fwd_ready_and_o = fwd_rdy;
    assign mem_rev_header_o    = hdr_q;
    assign mem_rev_data_o      = (state_q != e_rd_data) ? '0
                               : rd_hi ? rd_word[2*fill_width_lp-1:fill_width_lp]
                                       : rd_word[fill_width_lp-1:0];
    assign wr_count_o          = wr_count_q;
    assign error_o             = error_q;
endmodule

// File: tb/tb_bp_me_accel_wr_sink.sv
// Randomized and directed bench for bp_me_accel_wr_sink against a message-level reference model.
`timescale 1ns/1ps
module tb_bp_me_accel_wr_sink;
    import bp_me_accel_wr_sink_pkg::*;

    localparam int els_lp  = 16;
    localparam int wbits_lp = $clog2(2*els_lp);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       reset_n;
    bp_bedrock_mem_fwd_header_s fwd_hdr;
    logic [63:0]                fwd_dat;
    logic                       fwd_v, fwd_rdy;
    bp_bedrock_mem_rev_header_s rev_hdr;
    logic [63:0]                rev_dat;
    logic                       rev_v, rev_rdy;
    logic [15:0]                wr_count;
    logic                       error;

    bp_me_accel_wr_sink #(.els_p(els_lp)) dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .mem_fwd_header_i    (fwd_hdr),
        .mem_fwd_data_i      (fwd_dat),
        .mem_fwd_v_i         (fwd_v),
        .mem_fwd_ready_and_o (fwd_rdy),
        .mem_rev_header_o    (rev_hdr),
        .mem_rev_data_o      (rev_dat),
        .mem_rev_v_o         (rev_v),
        .mem_rev_ready_and_i (rev_rdy),
        .wr_count_o          (wr_count),
        .error_o             (error)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: 64-bit words keyed by (entry*2 + half)
    logic [63:0] mdl_mem [int];
    int unsigned mdl_cnt;
    logic        mdl_err;

    function automatic bp_bedrock_mem_fwd_header_s mk(input logic [3:0] t, input logic [2:0] s,
                                                      input logic [39:0] a);
        bp_bedrock_mem_fwd_header_s h;
        h          = '0;
        h.msg_type = t;
        h.size     = s;
        h.addr     = a;
        h.subop    = 4'($urandom);
        h.payload  = 8'($urandom);
        return h;
    endfunction

    task automatic fwd_beat(input bp_bedrock_mem_fwd_header_s h, input logic [63:0] d,
                            output int unsigned t);
        logic hit;
        hit = 1'b0;
        t   = 0;
        fwd_hdr = h;
        fwd_dat = d;
        fwd_v   = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fwd_rdy) begin
                hit = 1'b1;
                t   = cyc;
                break;
            end
        end
        check_eq("fwd_handshake", hit, 1'b1);
        if (hit) begin
            @(posedge clk);
            #1;
        end
        fwd_v = 1'b0;
    endtask

    task automatic rev_beat(input string tag, input bp_bedrock_mem_rev_header_s eh,
                            input logic [63:0] ed, input bit chk_d, input int stall,
                            output int unsigned t);
        logic hit;
        hit     = 1'b0;
        t       = 0;
        rev_rdy = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rev_v) begin
                hit = 1'b1;
                break;
            end
        end
        check_eq({tag, "_rev_v"}, hit, 1'b1);
        if (hit) begin
            for (int s = 0; s < stall; s++) begin
                check_eq({tag, "_stall_v"}, rev_v, 1'b1);
                check_eq({tag, "_stall_hdr"}, rev_hdr, eh);
                if (chk_d) check_eq({tag, "_stall_dat"}, rev_dat, ed);
                check_eq({tag, "_stall_fwd_rdy"}, fwd_rdy, 1'b0);
                @(negedge clk);
            end
            rev_rdy = 1'b1;
            check_eq({tag, "_hdr"}, rev_hdr, eh);
            if (chk_d) check_eq({tag, "_dat"}, rev_dat, ed);
            t = cyc;
            @(posedge clk);
            #1;
            rev_rdy = 1'b0;
        end
    endtask

    task automatic send_msg(input string tag, input bp_bedrock_mem_fwd_header_s h,
                            input logic [63:0] d0, input logic [63:0] d1, input int stall);
        bit          is_wr, is_rd, legal;
        int          nfwd, nrev, w;
        logic [63:0] exp_d [2];
        bit          known [2];
        int unsigned t;
        is_wr = (h.msg_type == 4'd3);
        is_rd = (h.msg_type == 4'd2);
        legal = (is_wr || is_rd) && (h.size == 3'd3 || (h.size == 3'd4 && !h.addr[3]));
        nfwd  = (legal && is_rd) ? 1 : ((h.size >= 3'd4) ? 2 : 1);
        nrev  = (legal && is_rd && h.size == 3'd4) ? 2 : 1;
        w     = int'(h.addr[3 +: wbits_lp]);
        for (int k = 0; k < 2; k++) begin
            exp_d[k] = '0;
            known[k] = 1'b1;
        end
        if (legal && is_rd) begin
            for (int k = 0; k < nrev; k++) begin
                known[k] = mdl_mem.exists(w + k);
                if (known[k]) exp_d[k] = mdl_mem[w + k];
            end
        end
        fwd_beat(h, d0, t);
        if (nfwd == 2) fwd_beat(h, d1, t);
        if (legal && is_wr) begin
            mdl_mem[w] = d0;
            if (h.size == 3'd4) mdl_mem[w + 1] = d1;
        end
        if (!legal) mdl_err = 1'b1;
        for (int k = 0; k < nrev; k++)
            rev_beat(tag, h, exp_d[k], known[k], (k == 0) ? stall : 0, t);
        if (legal && is_wr) mdl_cnt = (mdl_cnt + 1) & 32'hFFFF;
        @(negedge clk);
        check_eq({tag, "_count"}, wr_count, mdl_cnt[15:0]);
        check_eq({tag, "_error"}, error, mdl_err);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bp_bedrock_mem_fwd_header_s h1, h2;
        int unsigned                t0, t1, tx;
        logic [3:0]                 types [7];
        types   = '{4'd2, 4'd3, 4'd3, 4'd2, 4'd0, 4'd1, 4'd5};
        reset_n = 1'b0;
        fwd_v   = 1'b0;
        fwd_hdr = '0;
        fwd_dat = '0;
        rev_rdy = 1'b0;
        mdl_cnt = 0;
        mdl_err = 1'b0;

        #1;
        check_eq("rst_fwd_rdy", fwd_rdy, 1'b0);
        check_eq("rst_rev_v", rev_v, 1'b0);
        check_eq("rst_count", wr_count, 16'd0);
        check_eq("rst_error", error, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_eq("rdy_before_edge", fwd_rdy, 1'b0);
        @(posedge clk);
        #1;
        check_eq("rdy_after_edge", fwd_rdy, 1'b1);

        send_msg("wr16_20", mk(4'd3, 3'd4, 40'h20), {8{8'h11}}, {8{8'h22}}, 0);
        check_eq("wr16_20_cnt1", wr_count, 16'd1);
        send_msg("rd16_20_stall", mk(4'd2, 3'd4, 40'h20), '0, '0, 5);
        send_msg("wr16_30", mk(4'd3, 3'd4, 40'h30), {8{8'h33}}, {8{8'h44}}, 0);
        send_msg("wr8_38", mk(4'd3, 3'd3, 40'h38), {8{8'hAB}}, '0, 1);
        send_msg("rd8_30", mk(4'd2, 3'd3, 40'h30), '0, '0, 0);
        send_msg("rd8_38", mk(4'd2, 3'd3, 40'h38), '0, '0, 2);
        check_eq("rd8_38_cnt", wr_count, 16'd3);

        h1 = mk(4'd3, 3'd4, 40'h50);
        h2 = mk(4'd3, 3'd4, 40'h60);
        fork
            begin
                fwd_beat(h1, 64'h5050_0000_0000_0001, t0);
                fwd_beat(h1, 64'h5050_0000_0000_0002, tx);
                fwd_beat(h2, 64'h6060_0000_0000_0001, tx);
                fwd_beat(h2, 64'h6060_0000_0000_0002, tx);
            end
            begin
                rev_beat("b2b_1", h1, '0, 1'b1, 0, tx);
                rev_beat("b2b_2", h2, '0, 1'b1, 0, t1);
            end
        join
        check_eq("b2b_cycles", t1 - t0 + 1, 32'd6);
        mdl_mem[10] = 64'h5050_0000_0000_0001;
        mdl_mem[11] = 64'h5050_0000_0000_0002;
        mdl_mem[12] = 64'h6060_0000_0000_0001;
        mdl_mem[13] = 64'h6060_0000_0000_0002;
        mdl_cnt     = mdl_cnt + 2;
        @(negedge clk);
        check_eq("b2b_count", wr_count, 16'd5);
        @(posedge clk);
        #1;
        send_msg("rd16_60", mk(4'd2, 3'd4, 40'h60), '0, '0, 0);

        send_msg("wr16_00", mk(4'd3, 3'd4, 40'h00), {8{8'h55}}, {8{8'h66}}, 0);
        send_msg("err_wr16_08", mk(4'd3, 3'd4, 40'h08), {8{8'h77}}, {8{8'h88}}, 1);
        check_eq("err_sticky", error, 1'b1);
        check_eq("err_count", wr_count, 16'd6);
        send_msg("rd16_00", mk(4'd2, 3'd4, 40'h00), '0, '0, 0);

        h1 = mk(4'd3, 3'd4, 40'h40);
        fwd_beat(h1, {8{8'h99}}, tx);
        mdl_mem[8] = {8{8'h99}};
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_count", wr_count, 16'd0);
        check_eq("mid_rst_error", error, 1'b0);
        check_eq("mid_rst_fwd_rdy", fwd_rdy, 1'b0);
        check_eq("mid_rst_rev_v", rev_v, 1'b0);
        mdl_cnt = 0;
        mdl_err = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        send_msg("post_rst_wr8_48", mk(4'd3, 3'd3, 40'h48), {8{8'hC3}}, '0, 0);
        check_eq("post_rst_cnt", wr_count, 16'd1);
        send_msg("post_rst_rd16_40", mk(4'd2, 3'd4, 40'h40), '0, '0, 0);

        for (int e = 0; e < els_lp; e++)
            send_msg("prime", mk(4'd3, 3'd4, 40'(e * 16)), {$urandom, $urandom}, {$urandom, $urandom},
                     int'($urandom_range(0, 2)));

        for (int n = 0; n < 300; n++) begin
            logic [2:0]  sz;
            logic [39:0] a;
            int unsigned r;
            r  = $urandom_range(0, 9);
            sz = (r < 4) ? 3'd3 : (r < 8) ? 3'd4 : 3'($urandom_range(0, 7));
            a  = {$urandom, 8'($urandom) & 8'hF8};
            send_msg("rand", mk(types[$urandom_range(0, 6)], sz, a), {$urandom, $urandom},
                     {$urandom, $urandom}, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
